// File: rtl/sargantana_itag_ctrl_if.sv
// Port bundle between the icache control FSM / tag array and sargantana_itag_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface sargantana_itag_ctrl_if #(
  parameter int N_WAY = 4,
  parameter int TAG_W = 27,
  parameter int SET_W = 7
) ();
  logic                   lkp_valid_i;
  logic                   lkp_ready_o;
  logic [SET_W-1:0]       lkp_set_i;
  logic [TAG_W-1:0]       lkp_tag_i;
  logic                   rsp_valid_o;
  logic                   rsp_hit_o;
  logic [N_WAY-1:0]       rsp_way_o;
  logic                   rfl_valid_i;
  logic                   rfl_ready_o;
  logic [SET_W-1:0]       rfl_set_i;
  logic [TAG_W-1:0]       rfl_tag_i;
  logic [N_WAY-1:0]       rfl_way_o;
  logic                   flush_req_i;
  logic                   flush_ack_o;
  logic [N_WAY-1:0]       mem_req_o;
  logic                   mem_we_o;
  logic                   mem_vbit_o;
  logic                   mem_flush_o;
  logic [SET_W-1:0]       mem_addr_o;
  logic [TAG_W-1:0]       mem_data_o;
  logic [N_WAY*TAG_W-1:0] mem_tag_i;
  logic [N_WAY-1:0]       mem_vbit_i;

  modport slave (
    input  lkp_valid_i, lkp_set_i, lkp_tag_i,
    input  rfl_valid_i, rfl_set_i, rfl_tag_i,
    input  flush_req_i, mem_tag_i, mem_vbit_i,
    output lkp_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o,
    output rfl_ready_o, rfl_way_o, flush_ack_o,
    output mem_req_o, mem_we_o, mem_vbit_o, mem_flush_o, mem_addr_o, mem_data_o
  );

  modport master (
    output lkp_valid_i, lkp_set_i, lkp_tag_i,
    output rfl_valid_i, rfl_set_i, rfl_tag_i,
    output flush_req_i, mem_tag_i, mem_vbit_i,
    input  lkp_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o,
    input  rfl_ready_o, rfl_way_o, flush_ack_o,
    input  mem_req_o, mem_we_o, mem_vbit_o, mem_flush_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/sargantana_itag_ctrl.sv
// I-cache tag array sequencer: flush > refill > lookup arbitration, hit detection, victim choice.
// Define ICACHE_TAG_PLRU_EN for a per-set tree PLRU policy instead of the global round-robin pointer.
module sargantana_itag_ctrl #(
  parameter int N_WAY = 4,
  parameter int TAG_W = 27,
  parameter int SET_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  sargantana_itag_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(N_WAY);
  localparam int N_SET = 1 << SET_W;

  typedef enum logic [1:0] {IDLE, FLUSH, ACK} state_t;

  state_t             state_q, state_d;
  logic               rsp_pend_q;
  logic [SET_W-1:0]   set_q;
  logic [TAG_W-1:0]   tag_q;
  logic               mr_valid_q;
  logic [SET_W-1:0]   mr_set_q;
  logic [N_WAY-1:0]   mr_vbit_q;

  logic               is_idle, is_flush, is_ack;
  logic               rfl_ready, lkp_ready, rfl_acc, lkp_acc;
  logic [N_WAY-1:0]   hit_way;
  logic               rsp_hit;
  logic               mr_use;
  logic [N_WAY-1:0]   inv_way, policy_way, victim;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush_req_i) state_d = FLUSH;
      FLUSH:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign is_idle  = (state_q == IDLE);
  assign is_flush = (state_q == FLUSH);
  assign is_ack   = (state_q == ACK);

  assign rfl_ready = rstn_i & is_idle & ~bus.flush_req_i;
  assign lkp_ready = rfl_ready & ~bus.rfl_valid_i;
  assign rfl_acc   = bus.rfl_valid_i & rfl_ready;
  assign lkp_acc   = bus.lkp_valid_i & lkp_ready;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_pend_q <= 1'b0;
      set_q      <= '0;
      tag_q      <= '0;
    end else begin
      rsp_pend_q <= lkp_acc;
      if (lkp_acc) begin
        set_q <= bus.lkp_set_i;
        tag_q <= bus.lkp_tag_i;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_cmp
      assign hit_way[gi] = rsp_pend_q & bus.mem_vbit_i[gi]
                         & (bus.mem_tag_i[gi*TAG_W +: TAG_W] == tag_q);
    end
  endgenerate
  assign rsp_hit = |hit_way;

  // A refill write in the response cycle makes the just-read vbits stale, so clearing wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mr_valid_q <= 1'b0;
      mr_set_q   <= '0;
      mr_vbit_q  <= '0;
    end else if (is_flush || rfl_acc) begin
      mr_valid_q <= 1'b0;
    end else if (rsp_pend_q && !rsp_hit) begin
      mr_valid_q <= 1'b1;
      mr_set_q   <= set_q;
      mr_vbit_q  <= bus.mem_vbit_i;
    end
  end

  assign mr_use  = mr_valid_q & (mr_set_q == bus.rfl_set_i) & ~(&mr_vbit_q);
  assign inv_way = ~mr_vbit_q & (mr_vbit_q + N_WAY'(1));
  assign victim  = mr_use ? inv_way : policy_way;

`ifdef ICACHE_TAG_PLRU_EN
  // Tree bits: [0] root (1 = right pair), [1] picks within ways 0/1, [2] within ways 2/3.
  logic [2:0] plru_q [N_SET];
  logic [2:0] plru_d [N_SET];
  logic [2:0] plru_cur;

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [3:0] way);
    logic [2:0] r;
    r = b;
    case (way)
      4'b0001: begin r[0] = 1'b1; r[1] = 1'b1; end
      4'b0010: begin r[0] = 1'b1; r[1] = 1'b0; end
      4'b0100: begin r[0] = 1'b0; r[2] = 1'b1; end
      4'b1000: begin r[0] = 1'b0; r[2] = 1'b0; end
      default: r = b;
    endcase
    return r;
  endfunction

  assign plru_cur   = plru_q[bus.rfl_set_i];
  assign policy_way = plru_cur[0] ? (plru_cur[2] ? 4'b1000 : 4'b0100)
                                  : (plru_cur[1] ? 4'b0010 : 4'b0001);

  always_comb begin
    plru_d = plru_q;
    if (is_flush) begin
      for (int s = 0; s < N_SET; s++) plru_d[s] = 3'b000;
    end else begin
      if (rsp_hit) plru_d[set_q] = plru_touch(plru_d[set_q], hit_way);
      if (rfl_acc) plru_d[bus.rfl_set_i] = plru_touch(plru_d[bus.rfl_set_i], victim);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < N_SET; s++) plru_q[s] <= 3'b000;
    end else begin
      plru_q <= plru_d;
    end
  end
`else
  logic [PTR_W-1:0] rr_q;

  assign policy_way = N_WAY'(1) << rr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                rr_q <= '0;
    else if (rfl_acc && !mr_use) rr_q <= rr_q + PTR_W'(1);
  end
`endif

  always_comb begin
    bus.lkp_ready_o = lkp_ready;
    bus.rfl_ready_o = rfl_ready;
    bus.rsp_valid_o = rsp_pend_q;
    bus.rsp_hit_o   = rsp_hit;
    bus.rsp_way_o   = hit_way;
    bus.rfl_way_o   = rfl_acc ? victim : '0;
    bus.flush_ack_o = is_ack;
    bus.mem_flush_o = is_flush;
    bus.mem_we_o    = rfl_acc;
    bus.mem_vbit_o  = rfl_acc;
    bus.mem_req_o   = '0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    if (rfl_acc) begin
      bus.mem_req_o  = victim;
      bus.mem_addr_o = bus.rfl_set_i;
      bus.mem_data_o = bus.rfl_tag_i;
    end else if (lkp_acc) begin
      bus.mem_req_o  = '1;
      bus.mem_addr_o = bus.lkp_set_i;
    end
  end
endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Directed bench for sargantana_itag_ctrl with a behavioural single-port tag/valid array.
module tb_sargantana_itag_ctrl;
  localparam int N_WAY = 4;
  localparam int TAG_W = 27;
  localparam int SET_W = 7;
  localparam int N_SET = 1 << SET_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mem_init = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sargantana_itag_ctrl_if #(.N_WAY(N_WAY), .TAG_W(TAG_W), .SET_W(SET_W)) bus_if ();

  sargantana_itag_ctrl #(.N_WAY(N_WAY), .TAG_W(TAG_W), .SET_W(SET_W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_if)
  );

  // Array model: synchronous read into output registers, write on we, global valid clear.
  logic [TAG_W-1:0] arr_tag [N_WAY][N_SET];
  logic             arr_v   [N_WAY][N_SET];

  always @(posedge clk) begin
    if (mem_init || bus_if.mem_flush_o) begin
      for (int w = 0; w < N_WAY; w++)
        for (int s = 0; s < N_SET; s++) arr_v[w][s] <= 1'b0;
    end else begin
      for (int w = 0; w < N_WAY; w++) begin
        if (bus_if.mem_req_o[w]) begin
          if (bus_if.mem_we_o) begin
            arr_tag[w][bus_if.mem_addr_o] <= bus_if.mem_data_o;
            arr_v[w][bus_if.mem_addr_o]   <= bus_if.mem_vbit_o;
          end else begin
            bus_if.mem_tag_i[w*TAG_W +: TAG_W] <= arr_tag[w][bus_if.mem_addr_o];
            bus_if.mem_vbit_i[w]               <= arr_v[w][bus_if.mem_addr_o];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input string n, input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag);
    bus_if.lkp_valid_i = 1'b1;
    bus_if.lkp_set_i   = set;
    bus_if.lkp_tag_i   = tag;
    @(negedge clk);
    chk({n, "_lkp_ready"}, 32'(bus_if.lkp_ready_o), 32'd1);
    chk({n, "_mem_req"},   32'(bus_if.mem_req_o),   32'hF);
    chk({n, "_mem_addr"},  32'(bus_if.mem_addr_o),  32'(set));
    next_cycle();
    bus_if.lkp_valid_i = 1'b0;
  endtask

  task automatic chk_rsp(input string n, input logic hit, input logic [N_WAY-1:0] way);
    @(negedge clk);
    chk({n, "_rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
    chk({n, "_rsp_hit"},   32'(bus_if.rsp_hit_o),   32'(hit));
    chk({n, "_rsp_way"},   32'(bus_if.rsp_way_o),   32'(way));
    next_cycle();
  endtask

  task automatic do_refill(input string n, input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag,
                           input logic [N_WAY-1:0] way);
    bus_if.rfl_valid_i = 1'b1;
    bus_if.rfl_set_i   = set;
    bus_if.rfl_tag_i   = tag;
    @(negedge clk);
    chk({n, "_rfl_ready"}, 32'(bus_if.rfl_ready_o), 32'd1);
    chk({n, "_rfl_way"},   32'(bus_if.rfl_way_o),   32'(way));
    chk({n, "_mem_req"},   32'(bus_if.mem_req_o),   32'(way));
    chk({n, "_mem_we"},    32'({bus_if.mem_we_o, bus_if.mem_vbit_o}), 32'd3);
    chk({n, "_mem_data"},  32'(bus_if.mem_data_o),  32'(tag));
    next_cycle();
    bus_if.rfl_valid_i = 1'b0;
  endtask

  // Expected victims for the set-9 fill and the post-flush refill differ per policy.
`ifdef ICACHE_TAG_PLRU_EN
  logic [3:0] fill_way [5] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
  logic [3:0] a1_way       = 4'b0100;
  logic [3:0] post_flush   = 4'b0001;
`else
  logic [3:0] fill_way [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] a1_way       = 4'b0010;
  logic [3:0] post_flush   = 4'b0010;
`endif

  logic [SET_W-1:0] b2b_set [4] = '{7'd5, 7'd9, 7'd9, 7'd9};
  logic [TAG_W-1:0] b2b_tag [4] = '{27'h123, 27'hA1, 27'hA4, 27'hA0};
  logic             b2b_hit [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b2b_way [4];
    b2b_way = '{4'b0001, a1_way, 4'b0001, 4'b0000};

    bus_if.lkp_valid_i = 1'b1;
    bus_if.lkp_set_i   = '0;
    bus_if.lkp_tag_i   = '0;
    bus_if.rfl_valid_i = 1'b1;
    bus_if.rfl_set_i   = '0;
    bus_if.rfl_tag_i   = '0;
    bus_if.flush_req_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lkp_ready", 32'(bus_if.lkp_ready_o), 32'd0);
    chk("rst_rfl_ready", 32'(bus_if.rfl_ready_o), 32'd0);
    chk("rst_mem_req",   32'(bus_if.mem_req_o),   32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("rst_flush_ack", 32'(bus_if.flush_ack_o), 32'd0);
    bus_if.lkp_valid_i = 1'b0;
    bus_if.rfl_valid_i = 1'b0;
    rstn     = 1'b1;
    mem_init = 1'b0;
    next_cycle();

    do_lookup("miss5", 7'd5, 27'h123);
    chk_rsp("miss5", 1'b0, 4'b0000);
    do_refill("rfl5", 7'd5, 27'h123, 4'b0001);
    do_lookup("hit5", 7'd5, 27'h123);
    chk_rsp("hit5", 1'b1, 4'b0001);

    for (int i = 0; i < 5; i++)
      do_refill($sformatf("fill9_%0d", i), 7'd9, 27'hA0 + 27'(i), fill_way[i]);

    for (int i = 0; i < 5; i++) begin
      bus_if.lkp_valid_i = (i < 4);
      if (i < 4) begin
        bus_if.lkp_set_i = b2b_set[i];
        bus_if.lkp_tag_i = b2b_tag[i];
      end
      @(negedge clk);
      if (i < 4) chk($sformatf("b2b%0d_ready", i), 32'(bus_if.lkp_ready_o), 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i-1), 32'(bus_if.rsp_valid_o), 32'd1);
        chk($sformatf("b2b%0d_hit", i-1),   32'(bus_if.rsp_hit_o),   32'(b2b_hit[i-1]));
        chk($sformatf("b2b%0d_way", i-1),   32'(bus_if.rsp_way_o),   32'(b2b_way[i-1]));
      end
      next_cycle();
    end

    bus_if.flush_req_i = 1'b1;
    bus_if.rfl_valid_i = 1'b1;
    bus_if.rfl_set_i   = 7'd20;
    bus_if.rfl_tag_i   = 27'h55;
    bus_if.lkp_valid_i = 1'b1;
    bus_if.lkp_set_i   = 7'd5;
    bus_if.lkp_tag_i   = 27'h123;
    @(negedge clk);
    chk("fl0_readies", 32'({bus_if.rfl_ready_o, bus_if.lkp_ready_o}), 32'd0);
    chk("fl0_mem_req", 32'(bus_if.mem_req_o), 32'd0);
    chk("fl0_mem_flush", 32'(bus_if.mem_flush_o), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("fl1_mem_flush", 32'(bus_if.mem_flush_o), 32'd1);
    chk("fl1_readies", 32'({bus_if.rfl_ready_o, bus_if.lkp_ready_o}), 32'd0);
    chk("fl1_mem_req", 32'(bus_if.mem_req_o), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("fl2_flush_ack", 32'(bus_if.flush_ack_o), 32'd1);
    chk("fl2_mem_flush", 32'(bus_if.mem_flush_o), 32'd0);
    chk("fl2_readies", 32'({bus_if.rfl_ready_o, bus_if.lkp_ready_o}), 32'd0);
    next_cycle();
    bus_if.flush_req_i = 1'b0;
    @(negedge clk);
    chk("fl3_flush_ack", 32'(bus_if.flush_ack_o), 32'd0);
    chk("fl3_rfl_ready", 32'(bus_if.rfl_ready_o), 32'd1);
    chk("fl3_lkp_ready", 32'(bus_if.lkp_ready_o), 32'd0);
    chk("fl3_rfl_way",   32'(bus_if.rfl_way_o),   32'(post_flush));
    next_cycle();
    bus_if.rfl_valid_i = 1'b0;
    @(negedge clk);
    chk("fl4_lkp_ready", 32'(bus_if.lkp_ready_o), 32'd1);
    next_cycle();
    bus_if.lkp_valid_i = 1'b0;
    chk_rsp("fl_miss5", 1'b0, 4'b0000);
    do_lookup("hit20", 7'd20, 27'h55);
    chk_rsp("hit20", 1'b1, post_flush);

    do_lookup("rst20", 7'd20, 27'h55);
    rstn = 1'b0;
    bus_if.rfl_valid_i = 1'b1;
    #1;
    chk("rst2_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
    chk("rst2_rsp_hit",   32'(bus_if.rsp_hit_o),   32'd0);
    chk("rst2_rsp_way",   32'(bus_if.rsp_way_o),   32'd0);
    chk("rst2_rfl_ready", 32'(bus_if.rfl_ready_o), 32'd0);
    chk("rst2_mem_req",   32'(bus_if.mem_req_o),   32'd0);
    chk("rst2_mem_we",    32'(bus_if.mem_we_o),    32'd0);
    bus_if.rfl_valid_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    do_refill("rst2_rfl30", 7'd30, 27'h77, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
